// File: rtl/shot_entry_fsm.sv
// rtl/shot_entry_fsm.sv - keypad shot entry FSM: row, col, ENTER, then valid/ready offer
// Optional idle timeout enabled by defining SHOT_ENTRY_TIMEOUT_EN.
module shot_entry_fsm #(
   parameter int         GRID_SIZE      = 8,
   parameter int         COORD_W        = 3,
   parameter logic [3:0] ENTER_KEY      = 4'hE,
   parameter logic [3:0] BACK_KEY       = 4'hD,
   parameter logic [3:0] CLEAR_KEY      = 4'hC,
   parameter int         TIMEOUT_CYCLES = 500_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         key_value,
   input  logic               key_valid,
   input  logic               shot_ready,
   output logic               shot_valid,
   output logic [COORD_W-1:0] shot_row,
   output logic [COORD_W-1:0] shot_col,
   output logic [1:0]         entry_state,
   output logic               bad_key,
   output logic               entry_timeout
);

   typedef enum logic [1:0] {
      ST_ROW     = 2'd0,
      ST_COL     = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_OFFER   = 2'd3
   } state_t;

   localparam logic [4:0] GRID_LIMIT = 5'(GRID_SIZE);

   state_t             state_q, state_d;
   logic               shot_valid_q, shot_valid_d;
   logic [COORD_W-1:0] shot_row_q, shot_row_d;
   logic [COORD_W-1:0] shot_col_q, shot_col_d;
   logic               bad_key_q, bad_key_d;
   logic               entry_timeout_q, entry_timeout_d;

   logic               is_digit;
   logic               is_enter;
   logic               is_back;
   logic               is_clear;
   logic [COORD_W-1:0] digit_val;

   // GRID_SIZE never exceeds 10, so "below GRID_SIZE" also implies a decimal digit
   assign is_digit  = ({1'b0, key_value} < GRID_LIMIT) && (key_value <= 4'd9);
   assign is_enter  = (key_value == ENTER_KEY);
   assign is_back   = (key_value == BACK_KEY);
   assign is_clear  = (key_value == CLEAR_KEY);
   assign digit_val = COORD_W'(key_value);

   state_t key_state;
   logic   key_bad;
   logic [COORD_W-1:0] key_row;
   logic [COORD_W-1:0] key_col;

   always_comb begin
      key_state = state_q;
      key_bad   = 1'b0;
      key_row   = shot_row_q;
      key_col   = shot_col_q;
      if (key_valid) begin
         case (state_q)
            ST_ROW: begin
               if (is_digit) begin
                  key_row   = digit_val;
                  key_state = ST_COL;
               end else if (!(is_clear || is_back)) begin
                  key_bad = 1'b1;
               end
            end
            ST_COL: begin
               if (is_digit) begin
                  key_col   = digit_val;
                  key_state = ST_CONFIRM;
               end else if (is_back || is_clear) begin
                  key_state = ST_ROW;
               end else begin
                  key_bad = 1'b1;
               end
            end
            ST_CONFIRM: begin
               if (is_enter) begin
                  key_state = ST_OFFER;
               end else if (is_digit) begin
                  key_col = digit_val;
               end else if (is_back) begin
                  key_state = ST_COL;
               end else if (is_clear) begin
                  key_state = ST_ROW;
               end else begin
                  key_bad = 1'b1;
               end
            end
            default: begin
               // coordinates are frozen while offered; keys are dropped silently
               key_state = state_q;
            end
         endcase
      end
   end

`ifdef SHOT_ENTRY_TIMEOUT_EN
   logic [31:0] idle_cnt_q, idle_cnt_d;
   logic        idle_expired;
   logic        partial_entry;

   assign partial_entry = (state_q == ST_COL) || (state_q == ST_CONFIRM);
   assign idle_expired  = partial_entry && !key_valid &&
                          (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
   logic idle_expired;

   assign idle_expired = 1'b0;
`endif

   always_comb begin
      state_d         = key_state;
      shot_row_d      = key_row;
      shot_col_d      = key_col;
      bad_key_d       = key_bad;
      entry_timeout_d = 1'b0;
      if (state_q == ST_OFFER && shot_valid_q && shot_ready) begin
         state_d = ST_ROW;
      end
      if (idle_expired) begin
         state_d         = ST_ROW;
         entry_timeout_d = 1'b1;
      end
      shot_valid_d = (state_d == ST_OFFER);
   end

`ifdef SHOT_ENTRY_TIMEOUT_EN
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (key_valid || state_d == ST_ROW || state_d == ST_OFFER) begin
         idle_cnt_d = 32'd0;
      end else if (partial_entry) begin
         idle_cnt_d = idle_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q <= 32'd0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_ROW;
         shot_valid_q    <= 1'b0;
         shot_row_q      <= '0;
         shot_col_q      <= '0;
         bad_key_q       <= 1'b0;
         entry_timeout_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         shot_valid_q    <= shot_valid_d;
         shot_row_q      <= shot_row_d;
         shot_col_q      <= shot_col_d;
         bad_key_q       <= bad_key_d;
         entry_timeout_q <= entry_timeout_d;
      end
   end

   assign shot_valid    = shot_valid_q;
   assign shot_row      = shot_row_q;
   assign shot_col      = shot_col_q;
   assign entry_state   = state_q;
   assign bad_key       = bad_key_q;
   assign entry_timeout = entry_timeout_q;

endmodule

// File: tb/tb_shot_entry_fsm.sv
// tb/tb_shot_entry_fsm.sv - directed-vector bench for shot_entry_fsm
module tb_shot_entry_fsm;

   logic       clk;
   logic       rst_n;
   logic [3:0] key_value;
   logic       key_valid;
   logic       shot_ready;
   logic       shot_valid;
   logic [2:0] shot_row;
   logic [2:0] shot_col;
   logic [1:0] entry_state;
   logic       bad_key;
   logic       entry_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   shot_entry_fsm #(
      .GRID_SIZE      (8),
      .COORD_W        (3),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_value     (key_value),
      .key_valid     (key_valid),
      .shot_ready    (shot_ready),
      .shot_valid    (shot_valid),
      .shot_row      (shot_row),
      .shot_col      (shot_col),
      .entry_state   (entry_state),
      .bad_key       (bad_key),
      .entry_timeout (entry_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // returns on the falling edge right after the sampling edge
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_value = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      key_value = 4'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      key_value  = 4'h0;
      key_valid  = 1'b0;
      shot_ready = 1'b0;
      idle(3);
      check("rst_state", entry_state, 0);
      check("rst_valid", shot_valid, 0);
      check("rst_row", shot_row, 0);
      check("rst_col", shot_col, 0);
      check("rst_bad", bad_key, 0);
      check("rst_to", entry_timeout, 0);
      rst_n = 1'b1;

      // basic shot with ready already high
      shot_ready = 1'b1;
      press(4'h3);
      check("t1_state_col", entry_state, 1);
      check("t1_row", shot_row, 3);
      press(4'h5);
      check("t1_state_conf", entry_state, 2);
      press(4'hE);
      check("t1_valid", shot_valid, 1);
      check("t1_row_off", shot_row, 3);
      check("t1_col_off", shot_col, 5);
      check("t1_state_off", entry_state, 3);
      @(negedge clk);
      check("t1_valid_drop", shot_valid, 0);
      check("t1_state_back", entry_state, 0);

      // illegal digit in COL, then BACK editing
      shot_ready = 1'b0;
      press(4'h2);
      press(4'h9);
      check("t2_bad", bad_key, 1);
      check("t2_state", entry_state, 1);
      @(negedge clk);
      check("t2_bad_pulse", bad_key, 0);
      press(4'h4);
      check("t2_col4", shot_col, 4);
      press(4'hD);
      check("t2_back", entry_state, 1);
      press(4'h6);
      press(4'hE);
      check("t2_valid", shot_valid, 1);
      check("t2_row", shot_row, 2);
      check("t2_col", shot_col, 6);
      shot_ready = 1'b1;
      @(negedge clk);
      check("t2_xfer", shot_valid, 0);
      shot_ready = 1'b0;

      // held offer with a key injected mid-offer
      press(4'h1);
      press(4'h1);
      press(4'hE);
      idle(8);
      press(4'h7);
      check("t3_bad", bad_key, 0);
      check("t3_valid", shot_valid, 1);
      check("t3_row", shot_row, 1);
      check("t3_col", shot_col, 1);
      check("t3_state", entry_state, 3);
      idle(9);
      check("t3_still", shot_valid, 1);
      // key and ready in the same cycle: transfer happens, key dropped
      key_value  = 4'h5;
      key_valid  = 1'b1;
      shot_ready = 1'b1;
      @(negedge clk);
      key_valid  = 1'b0;
      shot_ready = 1'b0;
      check("t3_xfer", shot_valid, 0);
      check("t3_state0", entry_state, 0);
      check("t3_nolatch", shot_row, 1);
      check("t3_bad2", bad_key, 0);

      // bad key in ROW, CLEAR in ROW and COL
      press(4'hE);
      check("t4_bad", bad_key, 1);
      check("t4_state", entry_state, 0);
      press(4'hC);
      check("t4_clear_row", bad_key, 0);
      press(4'h4);
      press(4'hC);
      check("t4_clear", entry_state, 0);
      check("t4_row_kept", shot_row, 4);
      press(4'h0);
      press(4'h0);
      press(4'hE);
      check("t4_valid", shot_valid, 1);
      check("t4_row", shot_row, 0);
      check("t4_col", shot_col, 0);
      shot_ready = 1'b1;
      @(negedge clk);
      shot_ready = 1'b0;
      check("t4_xfer", entry_state, 0);

`ifdef SHOT_ENTRY_TIMEOUT_EN
      press(4'h5);
      idle(99);
      check("t5_pre", entry_timeout, 0);
      check("t5_pre_state", entry_state, 1);
      @(negedge clk);
      check("t5_to", entry_timeout, 1);
      check("t5_state", entry_state, 0);
      check("t5_to_bad", bad_key, 0);
      @(negedge clk);
      check("t5_to_pulse", entry_timeout, 0);
      press(4'h5);
      idle(98);
      press(4'h6);
      check("t5_key_wins", entry_timeout, 0);
      check("t5_key_state", entry_state, 2);
      check("t5_key_col", shot_col, 6);
      @(negedge clk);
      check("t5_no_to", entry_timeout, 0);
      press(4'hC);
`else
      press(4'h5);
      idle(150);
      check("t5_no_to", entry_timeout, 0);
      check("t5_persist", entry_state, 1);
      press(4'hC);
`endif

      // asynchronous reset during an offer
      press(4'h1);
      press(4'h2);
      press(4'hE);
      check("t6_valid", shot_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", shot_valid, 0);
      check("t6_async_state", entry_state, 0);
      check("t6_async_row", shot_row, 0);
      check("t6_async_col", shot_col, 0);
      idle(3);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_after", shot_valid, 0);
      check("t6_after_state", entry_state, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
